// File: rtl/game_pkg.sv
// Shared game/scene definitions for the pixel compositor.
// Holds screen size, sprite/bullet/shield/HP geometry, the 24-bit palette,
// game-state encodings, snapshot structs and small geometry helpers.
package game_pkg;

  // Screen extent (pixel coordinates are unsigned).
  localparam logic [10:0] SCR_W = 11'd640;
  localparam logic [9:0]  SCR_H = 10'd480;

  // Geometry, kept 12-bit signed so all box math shares one width.
  localparam logic signed [11:0] CHR_W      = 12'sd64;
  localparam logic signed [11:0] CHR_H      = 12'sd96;
  localparam logic signed [11:0] SQUAT_H    = 12'sd48;
  localparam logic signed [11:0] SHIELD_PAD = 12'sd8;
  localparam logic signed [11:0] BUL_W      = 12'sd16;
  localparam logic signed [11:0] BUL_H      = 12'sd8;
  localparam logic signed [11:0] HP_SEG_W   = 12'sd32;
  localparam logic signed [11:0] HP_SEG_H   = 12'sd12;
  localparam logic signed [11:0] HP_Y       = 12'sd16;
  localparam logic signed [11:0] HP_PITCH   = 12'sd36;
  localparam logic signed [11:0] HP_P_X0    = 12'sd16;
  localparam logic signed [11:0] HP_E_X0    = 12'sd508;
  localparam int                 HP_SEGS    = 3;

  // Palette {R,G,B}.
  localparam logic [23:0] COL_START    = 24'h000080;
  localparam logic [23:0] COL_WIN      = 24'h00C000;
  localparam logic [23:0] COL_LOSE     = 24'hC00000;
  localparam logic [23:0] COL_BG       = 24'h101010;
  localparam logic [23:0] COL_PLAYER   = 24'h2080FF;
  localparam logic [23:0] COL_ENEMY    = 24'hFF4020;
  localparam logic [23:0] COL_SHIELD   = 24'h00FFFF;
  localparam logic [23:0] COL_GOOD     = 24'hFFFF00;
  localparam logic [23:0] COL_BAD      = 24'hFF00FF;
  localparam logic [23:0] COL_HP       = 24'h00FF00;
  localparam logic [23:0] COL_HP_EMPTY = 24'h404040;

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_PLAY  = 2'b01,
    ST_WIN   = 2'b10,
    ST_LOSE  = 2'b11
  } game_state_e;

  typedef struct packed {
    logic signed [10:0] x;
    logic signed [9:0]  y;
    logic [1:0]         hp;
    logic               shield;
    logic               squat;
  } chr_snap_t;

  typedef struct packed {
    logic signed [10:0] x;
    logic signed [9:0]  y;
    logic               ise;
  } bul_snap_t;

  // state sits in the MSBs so an all-zero snapshot is ST_START.
  typedef struct packed {
    game_state_e state;
    chr_snap_t   pl;
    chr_snap_t   en;
    bul_snap_t   gb;
    bul_snap_t   bb;
  } snap_t;

  typedef struct packed {
    logic signed [11:0] x;
    logic signed [11:0] y;
    logic signed [11:0] w;
    logic signed [11:0] h;
  } box_t;

  function automatic logic signed [11:0] sx11(logic signed [10:0] v);
    return {v[10], v};
  endfunction

  function automatic logic signed [11:0] sx10(logic signed [9:0] v);
    return {{2{v[9]}}, v};
  endfunction

  // Character box; squatting keeps the bottom edge and halves the height.
  function automatic box_t chr_box(chr_snap_t c);
    box_t b;
    b.x = sx11(c.x);
    b.w = CHR_W;
    if (c.squat) begin
      b.y = sx10(c.y) + (CHR_H - SQUAT_H);
      b.h = SQUAT_H;
    end else begin
      b.y = sx10(c.y);
      b.h = CHR_H;
    end
    return b;
  endfunction

  function automatic box_t grow_box(box_t b);
    box_t g;
    g.x = b.x - SHIELD_PAD;
    g.y = b.y - SHIELD_PAD;
    g.w = b.w + SHIELD_PAD + SHIELD_PAD;
    g.h = b.h + SHIELD_PAD + SHIELD_PAD;
    return g;
  endfunction

  function automatic box_t bul_box(bul_snap_t u);
    box_t b;
    b.x = sx11(u.x);
    b.y = sx10(u.y);
    b.w = BUL_W;
    b.h = BUL_H;
    return b;
  endfunction

endpackage

// File: rtl/pixel_compositor_if.sv
// Pixel stream bundle for the compositor.
//   i_pix_valid/i_pix_x/i_pix_y : pixel request from the timing generator
//   o_pix_valid/o_rgb           : composited colour, two cycles later
// master = pixel source / colour sink, slave = compositor.
interface pixel_compositor_if;
  logic        i_pix_valid;
  logic [10:0] i_pix_x;
  logic [9:0]  i_pix_y;
  logic        o_pix_valid;
  logic [23:0] o_rgb;

  modport master (output i_pix_valid, i_pix_x, i_pix_y,
                  input  o_pix_valid, o_rgb);
  modport slave  (input  i_pix_valid, i_pix_x, i_pix_y,
                  output o_pix_valid, o_rgb);
endinterface

// File: rtl/box_hit.sv
// Combinational point-in-box test: org <= p < org+size on both axes.
// All operands are 12-bit signed so negative origins clip instead of wrapping.
//   org_x/org_y : box top-left, w/h : box size, px/py : pixel (non-negative)
//   hit         : pixel inside box
module box_hit (
  input  logic signed [11:0] org_x,
  input  logic signed [11:0] org_y,
  input  logic signed [11:0] w,
  input  logic signed [11:0] h,
  input  logic signed [11:0] px,
  input  logic signed [11:0] py,
  output logic               hit
);
  logic signed [11:0] end_x, end_y;
  assign end_x = org_x + w;
  assign end_y = org_y + h;
  assign hit = (px >= org_x) && (px < end_x) && (py >= org_y) && (py < end_y);
endmodule

// File: rtl/pixel_compositor.sv
// Pixel compositor: renders the game scene one pixel per cycle.
//   clk, rst_n     : clock, synchronous active-low reset
//   i_frame_start  : vblank pulse; game inputs are captured into a snapshot
//   i_state, i_player_*, i_enemy_*, i_goodbullet_*, i_badbullet_* : live game state
//   pif (slave)    : pixel request in, {R,G,B} out with fixed latency 2
// Stage 1 registers the hit flags of every drawable, stage 2 the priority colour.
module pixel_compositor
  import game_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_frame_start,
  input  logic [1:0]          i_state,
  input  logic signed [10:0]  i_player_x,
  input  logic signed [9:0]   i_player_y,
  input  logic [1:0]          i_player_hp,
  input  logic                i_player_shield,
  input  logic                i_player_squat,
  input  logic signed [10:0]  i_enemy_x,
  input  logic signed [9:0]   i_enemy_y,
  input  logic [1:0]          i_enemy_hp,
  input  logic                i_enemy_shield,
  input  logic                i_enemy_squat,
  input  logic signed [10:0]  i_goodbullet_x,
  input  logic signed [9:0]   i_goodbullet_y,
  input  logic                i_goodbullet_isE,
  input  logic signed [10:0]  i_badbullet_x,
  input  logic signed [9:0]   i_badbullet_y,
  input  logic                i_badbullet_isE,
  pixel_compositor_if.slave   pif
);

  localparam int STAGES = 2;

  typedef struct packed {
    game_state_e state;
    logic        off;
    logic        good;
    logic        bad;
    logic        pl;
    logic        en;
    logic        shield;
    logic        hp_on;
    logic        hp_lit;
  } s1_t;

  snap_t              snap, live;
  s1_t                s1_d, s1_q;
  logic [STAGES:1]    vld_pipe;
  logic [23:0]        col, rgb_q;
  logic signed [11:0] px, py;
  box_t               pl_b, en_b, pl_s, en_s, gb_b, bb_b;
  logic               pl_hit, en_hit, pls_hit, ens_hit, gb_hit, bb_hit;
  logic [HP_SEGS-1:0] hp_pl_hit, hp_en_hit, hp_pl_lit, hp_en_lit;

  always_comb begin
    live.state     = game_state_e'(i_state);
    live.pl.x      = i_player_x;
    live.pl.y      = i_player_y;
    live.pl.hp     = i_player_hp;
    live.pl.shield = i_player_shield;
    live.pl.squat  = i_player_squat;
    live.en.x      = i_enemy_x;
    live.en.y      = i_enemy_y;
    live.en.hp     = i_enemy_hp;
    live.en.shield = i_enemy_shield;
    live.en.squat  = i_enemy_squat;
    live.gb.x      = i_goodbullet_x;
    live.gb.y      = i_goodbullet_y;
    live.gb.ise    = i_goodbullet_isE;
    live.bb.x      = i_badbullet_x;
    live.bb.y      = i_badbullet_y;
    live.bb.ise    = i_badbullet_isE;
  end

  // Pixel coordinates are unsigned; zero-extend into the signed hit domain.
  assign px = {1'b0, pif.i_pix_x};
  assign py = {2'b00, pif.i_pix_y};

  assign pl_b = chr_box(snap.pl);
  assign en_b = chr_box(snap.en);
  assign pl_s = grow_box(pl_b);
  assign en_s = grow_box(en_b);
  assign gb_b = bul_box(snap.gb);
  assign bb_b = bul_box(snap.bb);

  box_hit u_pl  (.org_x(pl_b.x), .org_y(pl_b.y), .w(pl_b.w), .h(pl_b.h), .px(px), .py(py), .hit(pl_hit));
  box_hit u_en  (.org_x(en_b.x), .org_y(en_b.y), .w(en_b.w), .h(en_b.h), .px(px), .py(py), .hit(en_hit));
  box_hit u_pls (.org_x(pl_s.x), .org_y(pl_s.y), .w(pl_s.w), .h(pl_s.h), .px(px), .py(py), .hit(pls_hit));
  box_hit u_ens (.org_x(en_s.x), .org_y(en_s.y), .w(en_s.w), .h(en_s.h), .px(px), .py(py), .hit(ens_hit));
  box_hit u_gb  (.org_x(gb_b.x), .org_y(gb_b.y), .w(gb_b.w), .h(gb_b.h), .px(px), .py(py), .hit(gb_hit));
  box_hit u_bb  (.org_x(bb_b.x), .org_y(bb_b.y), .w(bb_b.w), .h(bb_b.h), .px(px), .py(py), .hit(bb_hit));

  for (genvar k = 0; k < HP_SEGS; k++) begin : g_hp
    localparam logic signed [11:0] SEG_OFS = HP_PITCH * 12'(k);
    localparam logic [1:0]         SEG_K   = 2'(k);
    box_hit u_pl (.org_x(HP_P_X0 + SEG_OFS), .org_y(HP_Y), .w(HP_SEG_W), .h(HP_SEG_H),
                  .px(px), .py(py), .hit(hp_pl_hit[k]));
    box_hit u_en (.org_x(HP_E_X0 + SEG_OFS), .org_y(HP_Y), .w(HP_SEG_W), .h(HP_SEG_H),
                  .px(px), .py(py), .hit(hp_en_hit[k]));
    assign hp_pl_lit[k] = hp_pl_hit[k] && (SEG_K < snap.pl.hp);
    assign hp_en_lit[k] = hp_en_hit[k] && (SEG_K < snap.en.hp);
  end

  always_comb begin
    s1_d        = '0;
    s1_d.state  = snap.state;
    s1_d.off    = (pif.i_pix_x >= SCR_W) || (pif.i_pix_y >= SCR_H);
    s1_d.good   = gb_hit && snap.gb.ise;
    s1_d.bad    = bb_hit && snap.bb.ise;
    s1_d.pl     = pl_hit;
    s1_d.en     = en_hit;
    // Ring = grown box minus the character box it surrounds.
    s1_d.shield = (pls_hit && snap.pl.shield && !pl_hit) ||
                  (ens_hit && snap.en.shield && !en_hit);
    s1_d.hp_on  = |{hp_pl_hit, hp_en_hit};
    s1_d.hp_lit = |{hp_pl_lit, hp_en_lit};
  end

  always_comb begin
    col = COL_BG;
    if (s1_q.off) col = '0;
    else begin
      unique case (s1_q.state)
        ST_START: col = COL_START;
        ST_WIN:   col = COL_WIN;
        ST_LOSE:  col = COL_LOSE;
        ST_PLAY: begin
          if      (s1_q.good)   col = COL_GOOD;
          else if (s1_q.bad)    col = COL_BAD;
          else if (s1_q.pl)     col = COL_PLAYER;
          else if (s1_q.en)     col = COL_ENEMY;
          else if (s1_q.shield) col = COL_SHIELD;
          else if (s1_q.hp_on)  col = s1_q.hp_lit ? COL_HP : COL_HP_EMPTY;
          else                  col = COL_BG;
        end
        default: col = COL_BG;
      endcase
    end
  end

  // A pixel arriving with i_frame_start already sampled its flags from the
  // old snapshot above; the new snapshot takes effect one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap     <= '0;
      vld_pipe <= '0;
      s1_q     <= '0;
      rgb_q    <= '0;
    end else begin
      if (i_frame_start) snap <= live;
      vld_pipe <= {vld_pipe[STAGES-1:1], pif.i_pix_valid};
      s1_q     <= s1_d;
      rgb_q    <= vld_pipe[1] ? col : 24'h0;
    end
  end

  assign pif.o_pix_valid = vld_pipe[STAGES];
  assign pif.o_rgb       = rgb_q;

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed bench for pixel_compositor: hand-placed scenes, expected colours
// taken from the palette constants.
module tb_pixel_compositor;
  import game_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic frame_start;
  logic [1:0] state;
  logic signed [10:0] pl_x, en_x, gb_x, bb_x;
  logic signed [9:0]  pl_y, en_y, gb_y, bb_y;
  logic [1:0] pl_hp, en_hp;
  logic pl_shield, pl_squat, en_shield, en_squat, gb_ise, bb_ise;

  int n_chk  = 0;
  int n_pass = 0;

  pixel_compositor_if pif ();

  pixel_compositor dut (
    .clk(clk), .rst_n(rst_n), .i_frame_start(frame_start), .i_state(state),
    .i_player_x(pl_x), .i_player_y(pl_y), .i_player_hp(pl_hp),
    .i_player_shield(pl_shield), .i_player_squat(pl_squat),
    .i_enemy_x(en_x), .i_enemy_y(en_y), .i_enemy_hp(en_hp),
    .i_enemy_shield(en_shield), .i_enemy_squat(en_squat),
    .i_goodbullet_x(gb_x), .i_goodbullet_y(gb_y), .i_goodbullet_isE(gb_ise),
    .i_badbullet_x(bb_x), .i_badbullet_y(bb_y), .i_badbullet_isE(bb_ise),
    .pif(pif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic load_frame();
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
  endtask

  // Single isolated pixel; result is visible two edges later.
  task automatic px_chk(input string tag, input int x, input int y, input logic [23:0] exp);
    @(negedge clk);
    pif.i_pix_valid = 1'b1; pif.i_pix_x = 11'(x); pif.i_pix_y = 10'(y);
    @(negedge clk);
    pif.i_pix_valid = 1'b0;
    @(negedge clk);
    chk(tag, {7'd0, pif.o_pix_valid, pif.o_rgb}, {7'd0, 1'b1, exp});
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; state = ST_START;
    pl_x = '0; pl_y = '0; pl_hp = '0; pl_shield = 1'b0; pl_squat = 1'b0;
    en_x = '0; en_y = '0; en_hp = '0; en_shield = 1'b0; en_squat = 1'b0;
    gb_x = '0; gb_y = '0; gb_ise = 1'b0; bb_x = '0; bb_y = '0; bb_ise = 1'b0;
    pif.i_pix_valid = 1'b0; pif.i_pix_x = '0; pif.i_pix_y = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, pif.o_pix_valid}, 32'd0);
    chk("rst_rgb", {8'd0, pif.o_rgb}, 32'd0);
    rst_n = 1'b1;

    // START snapshot, pixel (0,0), watch the intermediate cycle too.
    load_frame();
    @(negedge clk); pif.i_pix_valid = 1'b1; pif.i_pix_x = '0; pif.i_pix_y = '0;
    @(negedge clk); pif.i_pix_valid = 1'b0;
    chk("lat_mid", {7'd0, pif.o_pix_valid, pif.o_rgb}, 32'd0);
    @(negedge clk);
    chk("lat_start", {7'd0, pif.o_pix_valid, pif.o_rgb}, {7'd0, 1'b1, COL_START});
    @(negedge clk);
    chk("lat_after", {7'd0, pif.o_pix_valid, pif.o_rgb}, 32'd0);

    // Player body and squat.
    state = ST_PLAY; pl_x = 11'sd100; pl_y = 10'sd200; en_x = 11'sd400; en_y = 10'sd300;
    load_frame();
    px_chk("pl_tl", 100, 200, COL_PLAYER);
    px_chk("pl_br", 163, 295, COL_PLAYER);
    px_chk("pl_right", 164, 200, COL_BG);
    px_chk("en_body", 420, 350, COL_ENEMY);
    pl_squat = 1'b1; load_frame();
    px_chk("squat_top", 100, 200, COL_BG);
    px_chk("squat_body", 100, 248, COL_PLAYER);
    pl_squat = 1'b0;

    // Good bullet over the player, with and without isE.
    gb_x = 11'sd110; gb_y = 10'sd210; gb_ise = 1'b1; load_frame();
    px_chk("gb_on", 110, 210, COL_GOOD);
    gb_ise = 1'b0; load_frame();
    px_chk("gb_off", 110, 210, COL_PLAYER);

    // Negative origin clips at the left edge.
    pl_x = -11'sd32; load_frame();
    px_chk("clip_0", 0, 200, COL_PLAYER);
    px_chk("clip_31", 31, 200, COL_PLAYER);
    px_chk("clip_32", 32, 200, COL_BG);
    px_chk("nowrap_600", 600, 200, COL_BG);
    px_chk("nowrap_2016", 2016, 200, 24'h0);

    // HP bars, then live changes without frame_start must not show.
    pl_hp = 2'd1; en_hp = 2'd3; load_frame();
    px_chk("hp_pl0", 20, 20, COL_HP);
    px_chk("hp_pl1", 56, 20, COL_HP_EMPTY);
    px_chk("hp_gap", 50, 20, COL_BG);
    px_chk("hp_en2", 580, 20, COL_HP);
    pl_hp = 2'd3; en_hp = 2'd0; state = ST_WIN; pl_x = 11'sd40;
    px_chk("tear_pl1", 56, 20, COL_HP_EMPTY);
    px_chk("tear_en2", 580, 20, COL_HP);
    px_chk("tear_pl", 0, 200, COL_PLAYER);

    // Enemy shield ring and bad/good bullet priority.
    state = ST_PLAY; pl_x = -11'sd32; en_shield = 1'b1;
    bb_x = 11'sd410; bb_y = 10'sd310; bb_ise = 1'b1; load_frame();
    px_chk("ring_left", 395, 300, COL_SHIELD);
    px_chk("ring_top", 400, 292, COL_SHIELD);
    px_chk("ring_in", 400, 300, COL_ENEMY);
    px_chk("ring_right", 470, 300, COL_SHIELD);
    px_chk("ring_out", 472, 300, COL_BG);
    px_chk("bb_on", 410, 310, COL_BAD);
    gb_x = 11'sd410; gb_y = 10'sd310; gb_ise = 1'b1; load_frame();
    px_chk("gb_over_bb", 410, 310, COL_GOOD);

    // Off-screen pixels keep timing but output 0.
    px_chk("off_x", 640, 10, 24'h0);
    px_chk("off_y", 10, 480, 24'h0);

    // Back-to-back pixels with a bubble.
    @(negedge clk); pif.i_pix_valid = 1'b1; pif.i_pix_x = 11'd0;   pif.i_pix_y = 10'd200;
    @(negedge clk); pif.i_pix_x = 11'd300; pif.i_pix_y = 10'd100;
    @(negedge clk); pif.i_pix_valid = 1'b0;
    chk("str_a", {7'd0, pif.o_pix_valid, pif.o_rgb}, {7'd0, 1'b1, COL_PLAYER});
    @(negedge clk); pif.i_pix_valid = 1'b1; pif.i_pix_x = 11'd410; pif.i_pix_y = 10'd310;
    chk("str_b", {7'd0, pif.o_pix_valid, pif.o_rgb}, {7'd0, 1'b1, COL_BG});
    @(negedge clk); pif.i_pix_valid = 1'b0;
    chk("str_bubble", {7'd0, pif.o_pix_valid, pif.o_rgb}, 32'd0);
    @(negedge clk);
    chk("str_c", {7'd0, pif.o_pix_valid, pif.o_rgb}, {7'd0, 1'b1, COL_GOOD});

    // WIN / LOSE full-screen states.
    state = ST_WIN; load_frame();
    px_chk("win", 5, 5, COL_WIN);
    state = ST_LOSE; load_frame();
    px_chk("lose", 5, 5, COL_LOSE);

    // Pixel coincident with frame_start uses the old snapshot.
    @(negedge clk);
    state = ST_WIN; frame_start = 1'b1;
    pif.i_pix_valid = 1'b1; pif.i_pix_x = 11'd5; pif.i_pix_y = 10'd5;
    @(negedge clk); frame_start = 1'b0; pif.i_pix_x = 11'd6;
    @(negedge clk); pif.i_pix_valid = 1'b0;
    chk("fs_old", {7'd0, pif.o_pix_valid, pif.o_rgb}, {7'd0, 1'b1, COL_LOSE});
    @(negedge clk);
    chk("fs_new", {7'd0, pif.o_pix_valid, pif.o_rgb}, {7'd0, 1'b1, COL_WIN});

    // Reset while a pixel sits in stage 1.
    state = ST_PLAY; load_frame();
    @(negedge clk); pif.i_pix_valid = 1'b1; pif.i_pix_x = 11'd0; pif.i_pix_y = 10'd200;
    @(negedge clk); pif.i_pix_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("rst_flush_a", {7'd0, pif.o_pix_valid, pif.o_rgb}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_flush_b", {7'd0, pif.o_pix_valid, pif.o_rgb}, 32'd0);
    px_chk("rst_start", 0, 200, COL_START);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pixel_compositor.md
PIXEL_COMPOSITOR -- requirements
Module: pixel_compositor

Interface
REQ-001 SHALL: clk  in  1  sole clock; all logic on rising edge.
REQ-002 SHALL: rst_n  in  1  synchronous active-low reset, sampled on rising clk.
REQ-003 SHALL: i_frame_start  in  1  one-cycle pulse at vblank start; loads the game snapshot.
REQ-004 SHALL: i_pix_valid  in  1  qualifies i_pix_x/i_pix_y this cycle.
REQ-005 SHALL: i_pix_x  in  11 unsigned  pixel column, 0..639; i_pix_y  in  10 unsigned  pixel row, 0..479.
REQ-006 SHALL: i_state  in  2  game state; START=00, PLAY=01, WIN=10, LOSE=11.
REQ-007 SHALL: i_player_x/i_enemy_x  in  11 signed, i_player_y/i_enemy_y  in  10 signed  character top-left.
REQ-008 SHALL: i_player_hp/i_enemy_hp  in  2  hit points 0..3; i_*_shield, i_*_squat  in  1 each.
REQ-009 SHALL: i_goodbullet_x/i_badbullet_x  in  11 signed, *_y  in  10 signed, *_isE  in  1  bullet exists.
REQ-010 SHALL: o_pix_valid  out  1  i_pix_valid delayed by exactly 2 cycles.
REQ-011 SHALL: o_rgb  out  24  {R,G,B} colour for the pixel; 0 whenever o_pix_valid=0.

Function
REQ-012 SHALL: All game inputs latch into snapshot registers only on the cycle after i_frame_start=1; pixels are always rendered from the snapshot, never from live inputs (no tearing).
REQ-013 SHALL: When i_frame_start and i_pix_valid are both 1, that pixel uses the old snapshot; the new one applies from the next cycle.
REQ-014 SHALL: Pipeline: stage 1 registers coordinates and all hit flags; stage 2 registers the priority-selected colour. Fixed latency 2; throughput 1 pixel/cycle; bubbles propagate unchanged.
REQ-015 SHALL: Snapshot state START -> every pixel COL_START; WIN -> COL_WIN; LOSE -> COL_LOSE; PLAY -> scene per REQ-016..020.
REQ-016 SHALL: Hit test is x <= px < x+W and y <= py < y+H, evaluated in 12-bit signed arithmetic so negative or off-screen origins clip correctly and never wrap.
REQ-017 SHALL: Character box is 64x96; when squat=1 it is 64x48 with top edge at y+48 (bottom-aligned).
REQ-018 SHALL: When shield=1, a shield ring is drawn: the character box grown by 8 px on every side, excluding the character box itself.
REQ-019 SHALL: Bullet box is 16x8 and is drawn only when isE=1.
REQ-020 SHALL: HP bars: segment k (0..2) is 32x12 at y=16. Player segments start at x=16+36k; enemy segments start at x=508+36k. Segment k is lit (COL_HP) when k < hp, else COL_HP_EMPTY.
REQ-021 SHALL: Priority, highest first: good bullet (COL_GOOD), bad bullet (COL_BAD), player (COL_PLAYER), enemy (COL_ENEMY), shield ring (COL_SHIELD), HP bar, background COL_BG.
REQ-022 SHALL: Pixels with i_pix_x>=640 or i_pix_y>=480 output 0 but keep o_pix_valid timing.

Reset
REQ-023 SHALL: On rst_n=0 at a clock edge: both pipeline stages flush, o_pix_valid=0 and o_rgb=0 from the next cycle, and the snapshot clears to state=START with all positions, hp, flags and isE at 0.
REQ-024 SHALL: Reset mid-frame discards in-flight pixels. Until the next i_frame_start, valid pixels render COL_START.

Structure
REQ-025 SHALL: Screen size, sprite/bullet/shield/HP geometry, the COL_* 24-bit colours and the state encodings live in game_pkg; this module defines no duplicate literals.
REQ-026 SHALL: Contain one sub-module, box_hit: inputs are signed origin, width, height and pixel coordinates; output is a combinational in-box flag. It is instantiated once per drawable object.

Verification
REQ-027 SHALL: Reset, then START snapshot, pixel (0,0) valid -> 2 cycles later o_pix_valid=1, o_rgb=COL_START; cycles in between o_pix_valid=0, o_rgb=0.
REQ-028 SHALL: PLAY, player (100,200) squat=0 -> pixels (100,200) and (163,295) give COL_PLAYER, (164,200) gives COL_BG; set squat=1 and frame_start -> (100,200) gives COL_BG, (100,248) gives COL_PLAYER.
REQ-029 SHALL: Good bullet isE=1 at (110,210) over the player -> (110,210)=COL_GOOD; same with isE=0 -> COL_PLAYER.
REQ-030 SHALL: Player x=-32 -> (0,200)=COL_PLAYER and (31,200)=COL_PLAYER, (32,200)=COL_BG; no wrap artefact at x~2016.
REQ-031 SHALL: player_hp=1, enemy_hp=3 -> (20,20)=COL_HP, (56,20)=COL_HP_EMPTY, (580,20)=COL_HP; changing inputs mid-frame without frame_start leaves the output unchanged.
REQ-032 SHALL: rst_n=0 while a valid pixel is in stage 1 -> that pixel never appears; o_pix_valid stays 0.
